// File: rtl/unsign_and_sign_adder_pkg.sv
// Shared defaults and width-extension helpers for the three-operand signed/unsigned adder.
// The helpers work on a 64-bit container so any IN_W/OUT_W pair up to 64 bits can use them.
package unsign_and_sign_adder_pkg;

    localparam int unsigned IN_W_DEF  = 8;
    localparam int unsigned OUT_W_DEF = 16;
    localparam int unsigned EXT_W     = 64;

    typedef logic [EXT_W-1:0] ext_t;

    // Replicates bit (w-1) of val into every bit above it.
    function automatic ext_t sign_ext(input ext_t val, input int unsigned w);
        ext_t shifted;
        shifted = val << (EXT_W - w);
        return ext_t'($signed(shifted) >>> (EXT_W - w));
    endfunction

    // Clears every bit at position w and above.
    function automatic ext_t zero_ext(input ext_t val, input int unsigned w);
        ext_t mask;
        mask = {EXT_W{1'b1}} >> (EXT_W - w);
        return val & mask;
    endfunction

endpackage

// File: rtl/unsign_and_sign_adder_add3_ext.sv
// Extends three IN_W operands to OUT_W (zero- or sign-extension chosen by SIGNED)
// and adds them combinationally.
module add3_ext
    import unsign_and_sign_adder_pkg::*;
#(
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [IN_W-1:0]  c,
    output logic [OUT_W-1:0] sum
);

    // Two guard bits keep the three-term sum exact in either interpretation.
    if (OUT_W < IN_W + 2) begin : g_width_err
        $error("add3_ext: OUT_W must be at least IN_W+2");
    end
    if (OUT_W > EXT_W) begin : g_ext_err
        $error("add3_ext: OUT_W exceeds the extension container width");
    end

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] c_ext;

    if (SIGNED) begin : g_sign
        assign a_ext = OUT_W'(sign_ext(ext_t'(a), IN_W));
        assign b_ext = OUT_W'(sign_ext(ext_t'(b), IN_W));
        assign c_ext = OUT_W'(sign_ext(ext_t'(c), IN_W));
    end else begin : g_zero
        assign a_ext = OUT_W'(zero_ext(ext_t'(a), IN_W));
        assign b_ext = OUT_W'(zero_ext(ext_t'(b), IN_W));
        assign c_ext = OUT_W'(zero_ext(ext_t'(c), IN_W));
    end

    assign sum = a_ext + b_ext + c_ext;

endmodule

// File: rtl/unsign_and_sign_adder.sv
// Registered three-operand adder producing both the unsigned and the two's-complement
// sum of the same operands, one cycle after they are sampled.
module unsign_and_sign_adder
    import unsign_and_sign_adder_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [IN_W-1:0]  c,
    output logic [OUT_W-1:0] k_usgn,
    output logic [OUT_W-1:0] k_sgn
);

    logic [OUT_W-1:0] sum_usgn;
    logic [OUT_W-1:0] sum_sgn;

    add3_ext #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SIGNED (1'b0)
    ) u_add_usgn (
        .a   (a),
        .b   (b),
        .c   (c),
        .sum (sum_usgn)
    );

    add3_ext #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SIGNED (1'b1)
    ) u_add_sgn (
        .a   (a),
        .b   (b),
        .c   (c),
        .sum (sum_sgn)
    );

    // NOTE: non-blocking assignments so both registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_usgn <= '0;
            k_sgn  <= '0;
        end else begin
            k_usgn <= sum_usgn;
            k_sgn  <= sum_sgn;
        end
    end

endmodule

// File: tb/tb_unsign_and_sign_adder.sv
// Directed-vector bench for unsign_and_sign_adder: reset, latency, extension corners.
module tb_unsign_and_sign_adder;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [15:0] k_usgn;
    logic [15:0] k_sgn;

    int n_total = 0;
    int n_bad   = 0;

    unsign_and_sign_adder dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .c      (c),
        .k_usgn (k_usgn),
        .k_sgn  (k_sgn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] usgn;
        logic [15:0] sgn;
    } vec_t;

    localparam int N_VEC = 8;
    vec_t vecs [N_VEC];

    initial begin
        vecs[0] = '{8'd0,   8'd0,   8'd0,   16'h0000, 16'h0000};
        vecs[1] = '{8'd30,  8'd255, 8'd255, 16'h021C, 16'h001C};
        vecs[2] = '{8'd255, 8'd255, 8'd255, 16'h02FD, 16'hFFFD};
        vecs[3] = '{8'd30,  8'd1,   8'd1,   16'h0020, 16'h0020};
        vecs[4] = '{8'd127, 8'd127, 8'd127, 16'h017D, 16'h017D};
        vecs[5] = '{8'd128, 8'd128, 8'd128, 16'h0180, 16'hFE80};
        vecs[6] = '{8'd200, 8'd100, 8'd50,  16'h015E, 16'h005E};
        vecs[7] = '{8'd0,   8'd128, 8'd255, 16'h017F, 16'hFF7F};

        // Reset asserted with nonzero operands before any clock edge.
        rst = 1'b0;
        a = 8'd30; b = 8'd255; c = 8'd255;
        #2 rst = 1'b1;
        #1;
        check("rst_async_usgn", k_usgn, 16'h0000);
        check("rst_async_sgn",  k_sgn,  16'h0000);
        @(posedge clk);
        #7 rst = 1'b0;
        #1;
        check("rst_release_usgn", k_usgn, 16'h0000);
        check("rst_release_sgn",  k_sgn,  16'h0000);

        // Back-to-back vectors: result appears after exactly one edge.
        for (int i = 0; i < N_VEC; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                check($sformatf("v%0d_usgn", i - 1), k_usgn, vecs[i-1].usgn);
                check($sformatf("v%0d_sgn", i - 1),  k_sgn,  vecs[i-1].sgn);
            end
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
            if (i > 0) begin
                @(negedge clk);
                check($sformatf("v%0d_hold_usgn", i - 1), k_usgn, vecs[i-1].usgn);
                check($sformatf("v%0d_hold_sgn", i - 1),  k_sgn,  vecs[i-1].sgn);
            end
        end
        @(posedge clk);
        #1;
        check("v7_usgn", k_usgn, vecs[N_VEC-1].usgn);
        check("v7_sgn",  k_sgn,  vecs[N_VEC-1].sgn);

        // Reset pulsed mid-stream while a new operand set is in flight.
        a = vecs[2].a; b = vecs[2].b; c = vecs[2].c;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_usgn", k_usgn, 16'h0000);
        check("mid_rst_sgn",  k_sgn,  16'h0000);
        @(posedge clk);
        #1;
        check("mid_rst_edge_usgn", k_usgn, 16'h0000);
        check("mid_rst_edge_sgn",  k_sgn,  16'h0000);
        a = vecs[5].a; b = vecs[5].b; c = vecs[5].c;
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_wait_usgn", k_usgn, 16'h0000);
        @(posedge clk);
        #1;
        check("post_rst_usgn", k_usgn, vecs[5].usgn);
        check("post_rst_sgn",  k_sgn,  vecs[5].sgn);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
